// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding for the multi-cycle CPU control FSM
//
// Purpose : single source of the control FSM state encoding. The state bus is
//           exported as-is, and the program counter decodes it directly
//           (PC loads only in ST_PC_UPDATE).
// Contents: STATE_W   - width of the state bus
//           state_t   - FSM state enum with fixed encodings
package cpu_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 3'b000,
    ST_DECODE    = 3'b001,
    ST_EXECUTE   = 3'b010,
    ST_PC_UPDATE = 3'b011,
    ST_MEM       = 3'b100,
    ST_WB        = 3'b101,
    ST_FAULT     = 3'b110,
    ST_HALT      = 3'b111
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory request wait counter with timeout compare
//
// Purpose : counts the cycles that a memory request has been outstanding without
//           an ack. It flags expiry in the cycle where the request has gone unacked
//           for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables expiry.
// Ports   : clk      in  1  rising-edge clock
//           reset_n  in  1  asynchronous active-low reset
//           waiting  in  1  a memory request is outstanding this cycle
//           ack      in  1  the outstanding request is acked this cycle
//           expired  out 1  request has waited TIMEOUT_CYCLES cycles with no ack
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic waiting,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter holds the number of cycles already spent waiting, so the
  // cycle that completes TIMEOUT_CYCLES unacked cycles sees cnt_q == LIMIT.
  // An ack or any non-waiting state clears the counter. FETCH and MEM are
  // never entered back-to-back from each other, so this is equivalent to
  // clearing on entry.
  always_comb begin
    cnt_d = cnt_q;
    if (!waiting || ack) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the expiry cycle wins, so expiry is gated with !ack.
  assign expired = (TIMEOUT_CYCLES != 0) && waiting && !ack && (cnt_q >= LIMIT_V);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control FSM (fetch/decode/execute/mem/wb)
//
// Purpose : sequences one instruction at a time through FETCH, DECODE, EXECUTE,
//           MEM, WB and PC_UPDATE. Handshakes with instruction and data memory,
//           gates IR and register-file writes, and holds the registered branch
//           select. HALT and FAULT are absorbing until reset.
// Macro   : CPU_PERF_CNT_EN - when defined, cycle_count and instr_count are live
//           64-bit counters; otherwise both ports are tied to zero.
// Ports   : clk, reset_n                    clock, asynchronous active-low reset
//           imem_ack, dmem_ack              memory acks
//           is_load/is_store/is_branch      decoded class (valid DECODE..PC_UPDATE)
//           is_halt, branch_taken, stall    halt decode, ALU condition, freeze
//           state                           current FSM state (cpu_ctrl_pkg::state_t)
//           imem_req, ir_load               instruction fetch handshake / IR strobe
//           dmem_req, dmem_we               data access handshake / write enable
//           reg_write, instr_retired        WB and PC_UPDATE strobes (stall-gated)
//           pc_src                          registered branch select
//           halted, fault                   absorbing status
//           cycle_count, instr_count        performance counters
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_branch,
  input  logic               is_halt,
  input  logic               branch_taken,
  input  logic               stall,
  output logic [STATE_W-1:0] state,
  output logic               imem_req,
  output logic               ir_load,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_write,
  output logic               pc_src,
  output logic               instr_retired,
  output logic               halted,
  output logic               fault,
  output logic [63:0]        cycle_count,
  output logic [63:0]        instr_count
);

  state_t state_q, state_d;
  logic   pc_src_q, pc_src_d;
  logic   mem_waiting;
  logic   mem_ack;
  logic   timeout;
  logic   store_cls;

  // Load wins if both class bits are ever set together.
  assign store_cls = is_store & ~is_load;

  assign mem_waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign mem_ack     = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .waiting (mem_waiting),
    .ack     (mem_ack),
    .expired (timeout)
  );

  // Stall is not checked in FETCH and MEM: an ack there is a one-cycle event
  // and must be consumed even if a freeze is requested.
  always_comb begin
    state_d  = state_q;
    pc_src_d = pc_src_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          state_d = is_halt ? ST_HALT : ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (!stall) begin
          pc_src_d = is_branch & branch_taken;
          if (is_load || is_store) begin
            state_d = ST_MEM;
          end else if (is_branch) begin
            state_d = ST_PC_UPDATE;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = is_load ? ST_WB : ST_PC_UPDATE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        if (!stall) begin
          state_d = ST_PC_UPDATE;
        end
      end
      ST_PC_UPDATE: begin
        if (!stall) begin
          state_d  = ST_FETCH;
          pc_src_d = 1'b0;
        end
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      pc_src_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_src_q <= pc_src_d;
    end
  end

  assign state         = state_q;
  assign imem_req      = (state_q == ST_FETCH);
  // reset_n gate keeps the IR strobe quiet while reset is held with an ack present.
  assign ir_load       = reset_n & (state_q == ST_FETCH) & imem_ack;
  assign dmem_req      = (state_q == ST_MEM);
  assign dmem_we       = (state_q == ST_MEM) & store_cls;
  assign reg_write     = (state_q == ST_WB) & ~stall;
  assign pc_src        = pc_src_q;
  assign instr_retired = (state_q == ST_PC_UPDATE) & ~stall;
  assign halted        = (state_q == ST_HALT);
  assign fault         = (state_q == ST_FAULT);

`ifdef CPU_PERF_CNT_EN
  logic [63:0] cycle_count_q, cycle_count_d;
  logic [63:0] instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    if (state_q != ST_HALT && state_q != ST_FAULT) begin
      cycle_count_d = cycle_count_q + 64'd1;
    end
    if (instr_retired) begin
      instr_count_d = instr_count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count_q <= 64'd0;
      instr_count_q <= 64'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`else
  assign cycle_count = 64'd0;
  assign instr_count = 64'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam logic [2:0] FE = 3'b000, DE = 3'b001, EX = 3'b010, PU = 3'b011;
  localparam logic [2:0] ME = 3'b100, WB = 3'b101, FA = 3'b110, HA = 3'b111;
  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_HLT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_halt = 1'b0;
  logic branch_taken = 1'b0, stall = 1'b0;
  logic [2:0]  state;
  logic        imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_src;
  logic        instr_retired, halted, fault;
  logic [63:0] cycle_count, instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_halt(is_halt),
    .branch_taken(branch_taken), .stall(stall), .state(state), .imem_req(imem_req),
    .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .pc_src(pc_src), .instr_retired(instr_retired), .halted(halted), .fault(fault),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  // One cycle of stimulus plus the outputs expected in that cycle.
  // f = {ir_load, dmem_we, reg_write, pc_src, instr_retired}
  typedef struct {
    logic ia, da, stl, ld, st, br, hlt, tk;
    logic [2:0] s;
    logic [4:0] f;
  } vec_t;

  vec_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] m_cyc = 64'd0;
  logic [63:0] m_ins = 64'd0;
  int          cur_cls = C_ALU;
  logic        cur_tk = 1'b0;

  function automatic vec_t mk(input logic ia, input logic da, input logic stl, input int cls,
                              input logic tk, input logic [2:0] s, input logic [4:0] f);
    vec_t v;
    v.ia = ia; v.da = da; v.stl = stl; v.tk = tk; v.s = s; v.f = f;
    v.ld = (cls == C_LD); v.st = (cls == C_ST); v.br = (cls == C_BR); v.hlt = (cls == C_HLT);
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic ia, input logic da, input logic stl, input logic [2:0] s,
                     input logic [4:0] f);
    q.push_back(mk(ia, da, stl, cur_cls, cur_tk, s, f));
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference trace builder: expands one instruction into per-cycle expectations
  // from the phase rules (fetch wait, decode, execute, optional mem wait, optional
  // write-back, pc update), with stall cycles inserted where stall is honoured.
  task automatic plan(input int cls, input logic tk, input int iw, input int dw,
                      input int sd, input int se, input int sw, input int sp,
                      output logic done);
    logic p, isst;
    cur_cls = cls; cur_tk = tk; done = 1'b0; isst = (cls == C_ST);
    p = (cls == C_BR) && tk;
    if (iw >= TO) begin
      for (int i = 0; i < TO; i++) add(1'b0, rb(), rb(), FE, 5'b0);
      for (int i = 0; i < 3; i++) add(rb(), rb(), rb(), FA, 5'b0);
      done = 1'b1;
      return;
    end
    for (int i = 0; i < iw; i++) add(1'b0, rb(), rb(), FE, 5'b0);
    add(1'b1, rb(), rb(), FE, 5'b10000);
    for (int i = 0; i < sd; i++) add(rb(), rb(), 1'b1, DE, 5'b0);
    add(rb(), rb(), 1'b0, DE, 5'b0);
    if (cls == C_HLT) begin
      for (int i = 0; i < 3; i++) add(rb(), rb(), rb(), HA, 5'b0);
      done = 1'b1;
      return;
    end
    for (int i = 0; i < se; i++) add(rb(), rb(), 1'b1, EX, 5'b0);
    add(rb(), rb(), 1'b0, EX, 5'b0);
    if (cls == C_LD || isst) begin
      if (dw >= TO) begin
        for (int i = 0; i < TO; i++) add(rb(), 1'b0, rb(), ME, {1'b0, isst, 3'b0});
        for (int i = 0; i < 3; i++) add(rb(), rb(), rb(), FA, 5'b0);
        done = 1'b1;
        return;
      end
      for (int i = 0; i < dw; i++) add(rb(), 1'b0, rb(), ME, {1'b0, isst, 3'b0});
      add(rb(), 1'b1, rb(), ME, {1'b0, isst, 3'b0});
    end
    if (cls == C_ALU || cls == C_LD) begin
      for (int i = 0; i < sw; i++) add(rb(), rb(), 1'b1, WB, {3'b0, p, 1'b0});
      add(rb(), rb(), 1'b0, WB, {2'b0, 1'b1, p, 1'b0});
    end
    for (int i = 0; i < sp; i++) add(rb(), rb(), 1'b1, PU, {3'b0, p, 1'b0});
    add(rb(), rb(), 1'b0, PU, {3'b0, p, 1'b1});
  endtask

  // Applies and checks the queued vectors; called at posedge+1, returns at posedge+1.
  task automatic run_q(output int dreq_n);
    dreq_n = 0;
    foreach (q[i]) begin
      imem_ack = q[i].ia; dmem_ack = q[i].da; stall = q[i].stl;
      is_load = q[i].ld; is_store = q[i].st; is_branch = q[i].br; is_halt = q[i].hlt;
      branch_taken = q[i].tk;
      @(negedge clk);
      check($sformatf("outputs[%0d]", i),
            128'({state, imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_src,
                  instr_retired, halted, fault}),
            128'({q[i].s, q[i].s == FE, q[i].f[4], q[i].s == ME, q[i].f[3], q[i].f[2],
                  q[i].f[1], q[i].f[0], q[i].s == HA, q[i].s == FA}));
`ifdef CPU_PERF_CNT_EN
      check($sformatf("perf[%0d]", i), {cycle_count, instr_count}, {m_cyc, m_ins});
`else
      check($sformatf("perf_tied[%0d]", i), {cycle_count, instr_count}, 128'd0);
`endif
      if (dmem_req) dreq_n++;
      if (q[i].s != FA && q[i].s != HA) m_cyc++;
      if (q[i].f[0]) m_ins++;
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; imem_ack = 1'b1; stall = 1'b0;
    @(negedge clk);
    check("in_reset", 128'({state, ir_load, reg_write, instr_retired, pc_src, dmem_req}),
          128'({FE, 5'b0}));
    check("in_reset_perf", {cycle_count, instr_count}, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; imem_ack = 1'b0;
    m_cyc = 64'd0; m_ins = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   dn;
    logic done;
    int   k;

    // ALU op with zero-wait fetch, then taken branch, then not-taken branch
    // preceded by one FETCH cycle where stall is asserted (ignored).
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, C_ALU, 1'b0, FE, 5'b10000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_ALU, 1'b0, DE, 5'b00000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_ALU, 1'b0, EX, 5'b00000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_ALU, 1'b0, WB, 5'b00100));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_ALU, 1'b0, PU, 5'b00001));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, C_BR,  1'b1, FE, 5'b10000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_BR,  1'b1, DE, 5'b00000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_BR,  1'b1, EX, 5'b00000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_BR,  1'b1, PU, 5'b00011));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, C_BR,  1'b0, FE, 5'b00000));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, C_BR,  1'b0, FE, 5'b10000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_BR,  1'b0, DE, 5'b00000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_BR,  1'b0, EX, 5'b00000));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, C_BR,  1'b0, PU, 5'b00001));

    #1;
    do_reset();
    q = tbl;
    run_q(dn);

    // Load and store with three data wait cycles: dmem_req high four cycles.
    plan(C_LD, 1'b0, 0, 3, 0, 0, 0, 0, done);
    run_q(dn);
    check("load_dmem_req_cycles", 128'(dn), 128'd4);
    plan(C_ST, 1'b0, 0, 3, 0, 0, 0, 0, done);
    run_q(dn);
    check("store_dmem_req_cycles", 128'(dn), 128'd4);

    // Stall held three cycles in WB, and stalls in every honouring state.
    plan(C_ALU, 1'b0, 0, 0, 0, 0, 3, 0, done);
    run_q(dn);
    plan(C_BR, 1'b1, 1, 0, 2, 2, 0, 2, done);
    run_q(dn);

    // Fetch ack on the last allowed cycle, then fetch timeout (sticky fault).
    plan(C_ALU, 1'b0, TO - 1, 0, 0, 0, 0, 0, done);
    run_q(dn);
    plan(C_ALU, 1'b0, TO, 0, 0, 0, 0, 0, done);
    run_q(dn);
    do_reset();

    // Data ack on the last allowed cycle, then data timeout.
    plan(C_ST, 1'b0, 0, TO - 1, 0, 0, 0, 0, done);
    run_q(dn);
    plan(C_LD, 1'b0, 0, TO, 0, 0, 0, 0, done);
    run_q(dn);
    do_reset();

    // Halt: absorbing, perf counters frozen.
    plan(C_HLT, 1'b0, 1, 0, 1, 0, 0, 0, done);
    run_q(dn);
    do_reset();

    // Asynchronous reset while in MEM returns to FETCH immediately.
    plan(C_LD, 1'b0, 0, 3, 0, 0, 0, 0, done);
    k = 0;
    while (q[k].s != ME) k++;
    while (q.size() > k + 1) void'(q.pop_back());
    run_q(dn);
    dmem_ack = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_mem",
          128'({state, dmem_req, reg_write, instr_retired, cycle_count, instr_count}),
          128'({FE, 3'b000, 128'd0}));
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_cyc = 64'd0; m_ins = 64'd0;

    // Randomized instruction stream against the trace model.
    for (int n = 0; n < 80; n++) begin
      int cls, iw, dw;
      cls = ($urandom_range(0, 19) == 0) ? C_HLT : int'($urandom_range(0, 3));
      iw  = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
      dw  = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
      plan(cls, rb(), iw, dw, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), done);
      run_q(dn);
      if (done) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
